// File: rtl/sb_mem_slave_pkg.sv
// Shared constants and helpers for the system-bus memory slave.
// Holds bus field widths, the write-select encoding, the legal byte-mask
// encodings and a helper that expands a 4-bit byte enable into a 32-bit mask.
package sb_mem_slave_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned ByteSel      = 4;

  localparam logic              WriteEnable = 1'b1;
  localparam logic [31:0]       Zero32      = 32'h0000_0000;

  localparam logic [ByteSel-1:0] MaskByte = 4'b0001;
  localparam logic [ByteSel-1:0] MaskHalf = 4'b0011;
  localparam logic [ByteSel-1:0] MaskWord = 4'b1111;

  // Expand one enable bit per byte into a full-width bit mask.
  function automatic logic [DataWidth-1:0] lane_bits(input logic [ByteSel-1:0] be);
    logic [DataWidth-1:0] bits;
    for (int b = 0; b < ByteSel; b++) begin
      bits[8*b +: 8] = {8{be[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sb_ram_bank.sv
// Word-organised RAM bank: DEPTH_WORDS x 32 bits, four byte-write enables and a
// registered read port. The array has no reset; the read register only updates
// when re_i is high, so its value is held between reads.
//  clk_i    in   clock, rising edge
//  we_i     in   write strobe
//  be_i     in   per-byte write enables
//  addr_i   in   word index
//  wdata_i  in   lane-aligned write data
//  re_i     in   read strobe
//  rdata_o  out  registered read data
module sb_ram_bank #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AddrW       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sb_mem_slave.sv
// System-bus memory slave: accepts one request at a time from the arbiter's
// slave port, waits WAIT_STATES cycles, then commits the write or samples the
// read on the edge entering RESP and pulses s_ack_o for one cycle. Read data is
// returned right-aligned with unused upper bytes zeroed.
//  clk          in   clock, rising edge
//  rst          in   asynchronous reset, active-low
//  s_req        in   request valid, held until s_ack_o
//  s_rw         in   1 = write, 0 = read
//  s_addr       in   byte address
//  s_wdata      in   right-aligned write data
//  s_byte_mask  in   0001 byte, 0011 half, 1111 word
//  s_rdata_o    out  right-aligned read data, held until the next response
//  s_ack_o      out  one-cycle completion pulse
//  s_busy_o     out  high whenever not idle
//  s_err_o      out  access error, held until the next response
module sb_mem_slave
  import sb_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_req,
  input  logic                    s_rw,
  input  logic [MemAddrWidth-1:0] s_addr,
  input  logic [DataWidth-1:0]    s_wdata,
  input  logic [ByteSel-1:0]      s_byte_mask,
  output logic [DataWidth-1:0]    s_rdata_o,
  output logic                    s_ack_o,
  output logic                    s_busy_o,
  output logic                    s_err_o
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitLoad  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     run_q;
  logic                     rw_q;
  logic [MemAddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]     wdata_q;
  logic [ByteSel-1:0]       mask_q;
  logic                     ack_q;
  logic                     busy_q;
  logic                     err_q;
  logic                     rsp_rd_q;
  logic [1:0]               rsp_lane_q;
  logic [ByteSel-1:0]       rsp_mask_q;

  logic                     cur_rw;
  logic [MemAddrWidth-1:0]  cur_addr;
  logic [DataWidth-1:0]     cur_wdata;
  logic [ByteSel-1:0]       cur_mask;
  logic [MemAddrWidth-1:0]  off;
  logic [1:0]               lane;
  logic [IdxW-1:0]          idx;
  logic                     acc_err;
  logic                     is_write;
  logic                     enter_resp;
  logic                     ram_we;
  logic                     ram_re;
  logic [3:0]               ram_be;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;

  // A zero-wait accept enters RESP on the accepting edge, so decode must see the
  // live inputs while idle and the latched copy in every later state.
  always_comb begin
    cur_rw    = rw_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_mask  = mask_q;
    if (state_q == StIdle) begin
      cur_rw    = s_rw;
      cur_addr  = s_addr;
      cur_wdata = s_wdata;
      cur_mask  = s_byte_mask;
    end
  end

  // Underflow (addr below base) wraps to a large offset and fails the range test.
  assign off      = cur_addr - BASE_ADDR;
  assign lane     = off[1:0];
  assign idx      = off[IdxW+1:2];
  assign is_write = (cur_rw == WriteEnable);

  always_comb begin
    acc_err = 1'b0;
    case (cur_mask)
      MaskByte: acc_err = 1'b0;
      MaskHalf: acc_err = lane[0];
      MaskWord: acc_err = (lane != 2'd0);
      default:  acc_err = 1'b1;
    endcase
    if ({1'b0, off} >= SpanBytes) begin
      acc_err = 1'b1;
    end
  end

  // run_q stays low through reset and for the first edge after it, so a request
  // held during reset can never reach the RAM.
  assign enter_resp = run_q &&
                      (((state_q == StIdle) && s_req && (WAIT_STATES == 0)) ||
                       ((state_q == StWait) && (cnt_q == 4'd0)));

  assign ram_we    = enter_resp && is_write && !acc_err;
  assign ram_re    = enter_resp && !is_write && !acc_err;
  assign ram_be    = cur_mask << lane;
  assign ram_wdata = cur_wdata << {lane, 3'b000};

  sb_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AddrW       (IdxW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (idx),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      run_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_lane_q <= 2'd0;
      rsp_mask_q <= '0;
    end else begin
      run_q <= 1'b1;
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_req && run_q) begin
            rw_q    <= s_rw;
            addr_q  <= s_addr;
            wdata_q <= s_wdata;
            mask_q  <= s_byte_mask;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
      // Response flags are captured together with the RAM access.
      if (enter_resp) begin
        ack_q      <= 1'b1;
        err_q      <= acc_err;
        rsp_rd_q   <= !is_write && !acc_err;
        rsp_lane_q <= lane;
        rsp_mask_q <= cur_mask;
      end
    end
  end

  always_comb begin
    s_rdata_o = Zero32;
    if (rsp_rd_q) begin
      s_rdata_o = (ram_rdata >> {rsp_lane_q, 3'b000}) & lane_bits(rsp_mask_q);
    end
  end

  assign s_ack_o  = ack_q;
  assign s_busy_o = busy_q;
  assign s_err_o  = err_q;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Bench for sb_mem_slave: three instances (wait states 1/0/3, one with a
// non-zero base) checked against a byte-array reference model.
module tb_sb_mem_slave;

  localparam int unsigned NU    = 3;
  localparam int unsigned Depth = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [NU];
  logic        rw    [NU];
  logic [31:0] addr  [NU];
  logic [31:0] wdata [NU];
  logic [3:0]  mask  [NU];
  logic [31:0] rdata [NU];
  logic        ack   [NU];
  logic        busy  [NU];
  logic        err   [NU];

  logic [7:0]  mem_m [NU][Depth*4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    sb_mem_slave #(
      .DEPTH_WORDS (Depth),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .BASE_ADDR   ((g == 2) ? 32'h1000 : 32'h0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .s_req       (req[g]),
      .s_rw        (rw[g]),
      .s_addr      (addr[g]),
      .s_wdata     (wdata[g]),
      .s_byte_mask (mask[g]),
      .s_rdata_o   (rdata[g]),
      .s_ack_o     (ack[g]),
      .s_busy_o    (busy[g]),
      .s_err_o     (err[g])
    );
  end

  function automatic int ws_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
  endfunction

  function automatic logic [31:0] base_of(input int u);
    return (u == 2) ? 32'h1000 : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory; a legal access covers n bytes at an
  // n-aligned offset inside the window.
  task automatic model(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic e);
    logic [31:0] off;
    int n;
    int ln;
    off = a - base_of(u);
    ln  = int'(off % 4);
    case (m)
      4'b0001: n = 1;
      4'b0011: n = 2;
      4'b1111: n = 4;
      default: n = 0;
    endcase
    e  = (n == 0) || (off >= Depth * 4) || ((ln % n) != 0);
    rd = 32'h0;
    if (!e) begin
      for (int b = 0; b < n; b++) begin
        if (w) mem_m[u][off + b] = d[8*b +: 8];
        else   rd[8*b +: 8] = mem_m[u][off + b];
      end
    end
  endtask

  task automatic access(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit scramble, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    bit          got;
    model(u, w, a, d, m, exp_rd, exp_err);
    @(posedge clk); #1;
    check({tag, "/idle_busy"}, 32'(busy[u]), 32'd0);
    req[u] = 1'b1; rw[u] = w; addr[u] = a; wdata[u] = d; mask[u] = m;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      if (scramble) begin
        #1;
        addr[u] = $urandom; wdata[u] = $urandom; mask[u] = 4'($urandom); rw[u] = 1'($urandom);
      end
      @(negedge clk);
      if (ack[u]) got = 1'b1;
      else        check({tag, "/busy"}, 32'(busy[u]), 32'd1);
    end
    check({tag, "/latency"}, 32'(lat), 32'(ws_of(u) + 1));
    check({tag, "/err"}, 32'(err[u]), 32'(exp_err));
    check({tag, "/rdata"}, rdata[u], exp_rd);
    req[u] = 1'b0;
    @(negedge clk);
    check({tag, "/ack_pulse"}, 32'(ack[u]), 32'd0);
    check({tag, "/rdata_hold"}, rdata[u], exp_rd);
    check({tag, "/err_hold"}, 32'(err[u]), 32'(exp_err));
  endtask

  // Request held high: acks must recur every WAIT_STATES+2 cycles, with busy
  // low only in the idle cycle right after each ack.
  task automatic stream(input int u, input logic [31:0] a, input int periods);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          p;
    int          cyc;
    p = ws_of(u) + 2;
    model(u, 1'b0, a, 32'h0, 4'b1111, exp_rd, exp_err);
    @(posedge clk); #1;
    req[u] = 1'b1; rw[u] = 1'b0; addr[u] = a; mask[u] = 4'b1111;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack[u] && cyc < 40);
    check("stream/first_ack", 32'(ack[u]), 32'd1);
    for (int k = 0; k < periods; k++) begin
      for (int c = 1; c <= p; c++) begin
        @(negedge clk);
        check("stream/ack", 32'(ack[u]), 32'(c == p));
        check("stream/busy", 32'(busy[u]), 32'(c != 1));
        if (c == p) check("stream/rdata", rdata[u], exp_rd);
      end
    end
    req[u] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] old_rd;
    logic        old_err;
    for (int u = 0; u < NU; u++) begin
      req[u] = 1'b0; rw[u] = 1'b0; addr[u] = '0; wdata[u] = '0; mask[u] = '0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check("reset/ack", 32'(ack[u]), 32'd0);
      check("reset/busy", 32'(busy[u]), 32'd0);
      check("reset/err", 32'(err[u]), 32'd0);
      check("reset/rdata", rdata[u], 32'd0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Fill every word so the RAM holds known contents.
    for (int u = 0; u < NU; u++) begin
      for (int w = 0; w < int'(Depth); w++) begin
        access(u, 1'b1, base_of(u) + 32'(4 * w), $urandom, 4'b1111, 1'b0, "init");
      end
    end

    // Word write and read back.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, "t1_wr");
    access(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "t1_rd");
    check("t1/literal", rdata[0], 32'hDEADBEEF);

    // Byte write into the top lane of a zeroed word.
    access(0, 1'b1, 32'h10, 32'h0, 4'b1111, 1'b0, "t2_clr");
    access(0, 1'b1, 32'h13, 32'h000000A5, 4'b0001, 1'b0, "t2_wrb");
    access(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "t2_rdw");
    check("t2/literal_word", rdata[0], 32'hA5000000);
    access(0, 1'b0, 32'h13, 32'h0, 4'b0001, 1'b0, "t2_rdb");
    check("t2/literal_byte", rdata[0], 32'h000000A5);
    access(0, 1'b0, 32'h12, 32'h0, 4'b0011, 1'b0, "t2_rdh");
    check("t2/literal_half", rdata[0], 32'h0000A500);

    // Errors: misaligned half, out of range, bad mask, rejected writes.
    access(0, 1'b0, 32'h11, 32'h0, 4'b0011, 1'b0, "t3_mis");
    check("t3/mis_err", 32'(err[0]), 32'd1);
    access(0, 1'b0, 32'(Depth * 4), 32'h0, 4'b1111, 1'b0, "t3_oor");
    access(0, 1'b1, 32'h12, 32'h11223344, 4'b1111, 1'b0, "t3_wmis");
    access(0, 1'b1, 32'h10, 32'h11223344, 4'b0111, 1'b0, "t3_wbad");
    access(2, 1'b0, 32'h0FFC, 32'h0, 4'b1111, 1'b0, "t3_under");
    access(2, 1'b0, 32'h1000 + 32'(Depth * 4), 32'h0, 4'b1111, 1'b0, "t3_oor2");
    access(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "t3_rd");
    check("t3/unchanged", rdata[0], 32'hA5000000);

    // Back-to-back throughput.
    stream(1, 32'h20, 3);
    stream(2, 32'h1024, 3);
    stream(0, 32'h10, 2);

    // Reset in the middle of a write on the 3-wait-state unit.
    model(2, 1'b0, 32'h1020, 32'h0, 4'b1111, old_rd, old_err);
    @(posedge clk); #1;
    req[2] = 1'b1; rw[2] = 1'b1; addr[2] = 32'h1020; wdata[2] = ~old_rd; mask[2] = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    check("t5/busy_in_wait", 32'(busy[2]), 32'd1);
    rst = 1'b0;
    #1;
    check("t5/ack", 32'(ack[2]), 32'd0);
    check("t5/busy", 32'(busy[2]), 32'd0);
    check("t5/err", 32'(err[2]), 32'd0);
    check("t5/rdata", rdata[2], 32'd0);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5/no_ack", 32'(ack[2]), 32'd0);
    end
    access(2, 1'b0, 32'h1020, 32'h0, 4'b1111, 1'b0, "t5_rd");
    check("t5/old_value", rdata[2], old_rd);

    // Inputs scrambled after acceptance.
    for (int u = 0; u < NU; u++) begin
      access(u, 1'b1, base_of(u) + 32'h8, 32'hCAFEF00D, 4'b1111, 1'b1, "t6_wr");
      access(u, 1'b0, base_of(u) + 32'hA, 32'h0, 4'b0011, 1'b1, "t6_rd");
    end

    // Randomized mix, including illegal masks, misalignment and out-of-window.
    for (int i = 0; i < 150; i++) begin
      int u;
      u = i % NU;
      case ($urandom_range(0, 7))
        0, 1, 2: m = 4'b0001;
        3, 4:    m = 4'b0011;
        5, 6:    m = 4'b1111;
        default: m = 4'($urandom);
      endcase
      if (u == 2 && $urandom_range(0, 9) == 0) a = base_of(u) - 32'($urandom_range(1, 16));
      else a = base_of(u) + 32'($urandom_range(0, Depth * 4 + 8));
      access(u, 1'($urandom), a, $urandom, m, 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
